// File: rtl/fft_pkg.sv
// Constants and helpers shared by the FFT core and its post-processing blocks.
// Holds the drain-FSM state encoding used by fft_power_reorder.
package fft_pkg;

  localparam int FFT_N  = 1024;
  localparam int FFT_NN = 10;
  localparam int FFT_DW = 16;

  typedef enum logic {
    PW_IDLE  = 1'b0,
    PW_DRAIN = 1'b1
  } pw_state_t;

  // Reverses the low nn bits of x; the result is right-aligned.
  function automatic logic [31:0] bit_rev(input logic [31:0] x, input int nn);
    logic [31:0] r;
    r = {<<{x}};
    return r >> (32 - nn);
  endfunction

endpackage

// File: rtl/fft_power_reorder_if.sv
// Sample-in / power-out stream bundle for fft_power_reorder.
// With FFT_PWR_IDX_EN defined the bundle also carries the natural bin index do_idx.
interface fft_power_reorder_if #(
  parameter int DW = 16
`ifdef FFT_PWR_IDX_EN
  , parameter int NN = 10
`endif
);

  logic                 di_en;
  logic signed [DW-1:0] di_re;
  logic signed [DW-1:0] di_im;
  logic                 do_en;
  logic [2*DW-1:0]      do_pw;

`ifdef FFT_PWR_IDX_EN
  logic [NN-1:0]        do_idx;

  modport master (output di_en, di_re, di_im, input do_en, do_pw, do_idx);
  modport slave  (input di_en, di_re, di_im, output do_en, do_pw, do_idx);
`else
  modport master (output di_en, di_re, di_im, input do_en, do_pw);
  modport slave  (input di_en, di_re, di_im, output do_en, do_pw);
`endif

endinterface

// File: rtl/pw_bank_ram.sv
// Two-bank power buffer: one write port, one read port with registered data.
// Contents are never cleared; every bin is rewritten each frame before it is read.
module pw_bank_ram #(
  parameter int DEPTH = 513,
  parameter int AW    = 10,
  parameter int W     = 32
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic          i_wbank,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic          i_rbank,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [0:1][0:DEPTH-1];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_wbank][i_waddr] <= i_wdata;
  end

  always_ff @(posedge clock) begin
    if (i_re) o_rdata <= r_mem[i_rbank][i_raddr];
  end

endmodule

// File: rtl/fft_power_reorder.sv
// Bit-reversed FFT samples -> |X|^2 -> ping-pong buffer -> bins 0..N/2 in natural order.
// Optional macro FFT_PWR_IDX_EN adds the do_idx bin-index output.
module fft_power_reorder
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int NN = FFT_NN,
  parameter int DW = FFT_DW
) (
  input logic                clock,
  input logic                reset,
  fft_power_reorder_if.slave bus
);

  localparam int            PW   = 2 * DW;
  localparam logic [NN-1:0] HALF = NN'(N / 2);
  localparam logic [NN-1:0] LAST = NN'(N - 1);

  // Both squares are non-negative, so their sum fits PW unsigned bits.
  function automatic logic [PW-1:0] power_sum(input logic signed [PW-1:0] a,
                                              input logic signed [PW-1:0] b);
    return $unsigned(a) + $unsigned(b);
  endfunction

  logic [NN-1:0]        r_cnt;
  logic [NN-1:0]        w_k;
  logic signed [PW-1:0] w_re_x;
  logic signed [PW-1:0] w_im_x;

  logic signed [PW-1:0] r_sq_re_p0;
  logic signed [PW-1:0] r_sq_im_p0;
  logic [NN-1:0]        r_k_p0;
  logic                 r_last_p0;
  logic                 r_vld_p0;

  logic [PW-1:0]        r_pw_p1;
  logic [NN-1:0]        r_k_p1;
  logic                 r_last_p1;
  logic                 r_vld_p1;

  logic                 w_we;
  logic                 w_frame_done;
  logic                 r_wbank;

  pw_state_t            r_state;
  pw_state_t            w_state_nxt;
  logic [NN-1:0]        r_rd_addr;
  logic                 w_rd_en;
  logic                 r_rd_vld_p2;
  logic [PW-1:0]        w_rdata;

  assign w_k    = NN'(bit_rev(32'(r_cnt), NN));
  assign w_re_x = PW'(bus.di_re);
  assign w_im_x = PW'(bus.di_im);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      if (bus.di_en) r_cnt <= r_cnt + NN'(1);
      r_vld_p0 <= bus.di_en;
      r_vld_p1 <= r_vld_p0;
    end
  end

  // Stage p0: squares; stage p1: power sum. Data holds across input gaps.
  always_ff @(posedge clock) begin
    if (bus.di_en) begin
      r_sq_re_p0 <= w_re_x * w_re_x;
      r_sq_im_p0 <= w_im_x * w_im_x;
      r_k_p0     <= w_k;
      r_last_p0  <= (r_cnt == LAST);
    end
    if (r_vld_p0) begin
      r_pw_p1   <= power_sum(r_sq_re_p0, r_sq_im_p0);
      r_k_p1    <= r_k_p0;
      r_last_p1 <= r_last_p0;
    end
  end

  // Mirror-half bins (k > N/2) are dropped; the last sample closes the frame.
  assign w_we         = r_vld_p1 && (r_k_p1 <= HALF);
  assign w_frame_done = r_vld_p1 && r_last_p1;

  always_ff @(posedge clock) begin
    if (reset)             r_wbank <= 1'b0;
    else if (w_frame_done) r_wbank <= ~r_wbank;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= PW_IDLE;
      r_rd_addr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_addr <= (r_state == PW_DRAIN) ? r_rd_addr + NN'(1) : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      PW_IDLE:  if (w_frame_done)       w_state_nxt = PW_DRAIN;
      PW_DRAIN: if (r_rd_addr == HALF)  w_state_nxt = PW_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en = (r_state == PW_DRAIN);
  end

  pw_bank_ram #(
    .DEPTH (N / 2 + 1),
    .AW    (NN),
    .W     (PW)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_we),
    .i_wbank (r_wbank),
    .i_waddr (r_k_p1),
    .i_wdata (r_pw_p1),
    .i_re    (w_rd_en),
    .i_rbank (~r_wbank),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rdata)
  );

`ifdef FFT_PWR_IDX_EN
  logic [NN-1:0] r_rd_idx_p2;

  always_ff @(posedge clock) begin
    if (w_rd_en) r_rd_idx_p2 <= r_rd_addr;
  end
`endif

  // Stage p2: RAM read data valid; output stage follows one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_vld_p2 <= 1'b0;
      bus.do_en   <= 1'b0;
      bus.do_pw   <= '0;
`ifdef FFT_PWR_IDX_EN
      bus.do_idx  <= '0;
`endif
    end else begin
      r_rd_vld_p2 <= w_rd_en;
      bus.do_en   <= r_rd_vld_p2;
      if (r_rd_vld_p2) begin
        bus.do_pw  <= w_rdata;
`ifdef FFT_PWR_IDX_EN
        bus.do_idx <= r_rd_idx_p2;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fft_power_reorder.sv
// Scoreboard bench for fft_power_reorder: a reference model queues each frame's
// natural-order power bins and the cycle its burst must start; a monitor compares.
module tb_fft_power_reorder;

  localparam int N    = 1024;
  localparam int NN   = 10;
  localparam int DW   = 16;
  localparam int HALF = N / 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  fft_power_reorder_if #(
    .DW(DW)
`ifdef FFT_PWR_IDX_EN
    , .NN(NN)
`endif
  ) bus ();

  fft_power_reorder #(.N(N), .NN(NN), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int     n_chk = 0;
  int     n_err = 0;
  longint cyc   = 0;
  longint exp_pw_q[$];
  longint exp_start_q[$];
  longint mdl_bins[0:HALF];
  longint cap[0:HALF];
  int     mdl_n    = 0;
  longint last_exp = 0;
  bit     prev_en  = 1'b0;
  int     run      = 0;
  int     bursts   = 0;
  int     b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < NN; i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

  task automatic send(input int re, input int im);
    int     k;
    longint pw;
    @(negedge clock);
    bus.di_en = 1'b1;
    bus.di_re = DW'(re);
    bus.di_im = DW'(im);
    k  = brev(mdl_n);
    pw = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    if (k <= HALF) mdl_bins[k] = pw;
    mdl_n++;
    if (mdl_n == N) begin
      mdl_n = 0;
      for (int b = 0; b <= HALF; b++) exp_pw_q.push_back(mdl_bins[b]);
      // sampled on edge cyc+1, first bin visible after edge cyc+5
      exp_start_q.push_back(cyc + 5);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.di_en = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    idle(1);
    while ((exp_pw_q.size() != 0 || bus.do_en) && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    check({tag, "_drained"}, exp_pw_q.size(), 0);
    idle(3);
    check({tag, "_en_low"}, bus.do_en, 0);
    check({tag, "_pw_hold"}, bus.do_pw, last_exp);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.do_en) begin
        if (!prev_en) begin
          run = 0;
          bursts++;
          if (exp_start_q.size() == 0) check("burst_unexpected", 1, 0);
          else check("latency", cyc, exp_start_q.pop_front());
        end
        if (exp_pw_q.size() == 0) begin
          check("do_en_unexpected", 1, 0);
        end else begin
          last_exp = exp_pw_q.pop_front();
          check("do_pw", bus.do_pw, last_exp);
        end
`ifdef FFT_PWR_IDX_EN
        check("do_idx", bus.do_idx, run);
`endif
        if (run <= HALF) cap[run] = bus.do_pw;
        run++;
      end else if (prev_en) begin
        check("burst_len", run, HALF + 1);
      end
    end
    prev_en = bus.do_en;
  end

  initial begin
    bus.di_en = 1'b0;
    bus.di_re = '0;
    bus.di_im = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_do_en", bus.do_en, 0);
    check("rst_do_pw", bus.do_pw, 0);
    reset = 1'b0;

    // constant 100 + j0
    b0 = bursts;
    for (int n = 0; n < N; n++) send(100, 0);
    wait_drain("const100");
    check("const100_bursts", bursts - b0, 1);
    check("const100_bin0", cap[0], 10000);
    check("const100_bin512", cap[HALF], 10000);

    // ramp re = n: bin k holds brev(k)^2
    for (int n = 0; n < N; n++) send(n, 0);
    wait_drain("ramp");
    check("ramp_bin0", cap[0], 0);
    check("ramp_bin1", cap[1], 262144);
    check("ramp_bin2", cap[2], 65536);
    check("ramp_bin512", cap[HALF], 1);

    // most negative corner: full-scale power
    for (int n = 0; n < N; n++) send(-32768, -32768);
    wait_drain("negmax");
    check("negmax_bin0", cap[0], 64'h8000_0000);
    check("negmax_bin512", cap[HALF], 64'h8000_0000);

    // ramp with a gap after every sample
    b0 = bursts;
    for (int n = 0; n < N; n++) begin
      send(n, 0);
      idle(1);
    end
    wait_drain("gaps");
    check("gaps_bursts", bursts - b0, 1);
    check("gaps_bin1", cap[1], 262144);
    check("gaps_bin2", cap[2], 65536);
    check("gaps_bin512", cap[HALF], 1);

    // back-to-back frames, second written while the first drains
    b0 = bursts;
    for (int n = 0; n < N; n++) send(1, 0);
    for (int n = 0; n < N; n++) send(2, 0);
    wait_drain("b2b");
    check("b2b_bursts", bursts - b0, 2);
    check("b2b_last_bin0", cap[0], 4);

    // reset in the middle of a partial frame
    for (int n = 0; n < 500; n++) send(7, 0);
    @(negedge clock);
    reset     = 1'b1;
    bus.di_en = 1'b0;
    mdl_n     = 0;
    repeat (2) @(negedge clock);
    check("rst2_do_en", bus.do_en, 0);
    check("rst2_do_pw", bus.do_pw, 0);
    reset = 1'b0;
    last_exp = 0;
    b0 = bursts;
    for (int n = 0; n < N; n++) send(3, 0);
    wait_drain("after_rst");
    check("after_rst_bursts", bursts - b0, 1);
    check("after_rst_bin0", cap[0], 9);
    check("after_rst_bin512", cap[HALF], 9);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fft_power_reorder.md
FFT_POWER_REORDER -- requirements
Module: fft_power_reorder

Interface
REQ-001 SHALL have parameter N, default 1024, FFT length (power of two).
REQ-002 SHALL have parameter NN, default 10, log2(N).
REQ-003 SHALL have parameter DW, default 16, signed input component width.
REQ-004 SHALL have port clock, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port di_en, input, 1, input sample valid; one FFT output sample per cycle while high.
REQ-007 SHALL have port di_re, input, DW, signed real part, in FFT bit-reversed order.
REQ-008 SHALL have port di_im, input, DW, signed imaginary part.
REQ-009 SHALL have port do_en, output, 1, power bin valid.
REQ-010 SHALL have port do_pw, output, 2*DW, unsigned power re^2+im^2.

Function
REQ-011 SHALL count accepted samples n = 0..N-1 per frame; the count advances only on cycles with di_en high.
REQ-012 SHALL treat sample n as bin k = bit-reverse of n over NN bits.
REQ-013 SHALL compute re*re + im*im exactly in 2*DW unsigned bits, with no overflow (max 2^(2*DW-1)).
REQ-014 SHALL use a 2-stage power pipeline: products registered, then sum registered.
REQ-015 SHALL write each sum to address k of the current write bank of a ping-pong buffer (2 banks x N/2+1 words).
REQ-016 SHALL discard bins k > N/2 (mirror half), with no write.
REQ-017 SHALL swap banks and start a drain when the N-th sample's sum is written.
REQ-018 SHALL, on drain, assert do_en for exactly N/2+1 consecutive cycles, with do_pw = bins 0,1,...,N/2 in natural order.
REQ-019 SHALL make latency exactly 4 cycles: do_en rises on the 4th rising edge after the edge that samples the last input of a frame.
REQ-020 SHALL hold do_en low and do_pw at its last value outside a drain.
REQ-021 SHALL accept a new frame during a drain without stall, writing into the other bank.
REQ-022 SHALL never see a frame complete while a drain is active, since N input cycles exceed N/2+1 drain cycles.
REQ-023 SHALL allow gaps in di_en mid-frame; the pipeline and count hold their state across gaps.
REQ-024 SHALL have drain FSM states IDLE -> DRAIN (on frame complete) -> IDLE (after bin N/2).

Reset
REQ-025 SHALL, on reset, clear the sample count, pipeline valids, bank pointer and FSM to IDLE, set do_en=0 and do_pw=0, and discard any partial frame or in-progress drain.
REQ-026 SHALL NOT clear buffer RAM contents on reset.

Configuration
REQ-027 SHALL, with macro FFT_PWR_IDX_EN defined, add output port do_idx [NN-1:0] carrying the natural bin index (0..N/2) aligned with do_en, reset to 0.
REQ-028 SHALL, without FFT_PWR_IDX_EN, have no do_idx port; all other behaviour is identical.

Structure
REQ-029 SHALL place FFT_N, FFT_NN, FFT_DW and a bit-reverse function in shared package fft_pkg, also used by the FFT.
REQ-030 SHALL implement the ping-pong RAM as sub-module pw_bank_ram (one write port, one registered read port).

Verification
REQ-031 Constant input re=100, im=0 for 1024 samples -> 513 do_en cycles, every do_pw = 10000.
REQ-032 Sample n carries re=n, im=0 -> bin0=0, bin1=262144, bin2=65536, bin512=1.
REQ-033 All samples re=-32768, im=-32768 -> every do_pw = 0x80000000.
REQ-034 di_en alternating 1/0 over 2048 cycles with REQ-032 data -> output identical to contiguous case; do_en contiguous 513 cycles.
REQ-035 Two back-to-back frames (re=1 then re=2, im=0) -> two bursts of 513 with values 1 then 4; no gap corruption.
REQ-036 reset pulsed after 500 samples, then one full frame of re=3 -> exactly one burst, all do_pw=9.
